// File: rtl/prv32_exec_ctrl.sv
// rtl/prv32_exec_ctrl.sv - RV32I execute-stage controller that drives prv32_ALU and returns a registered response
// Optional performance counters are enabled by defining EXEC_CTRL_PERF_EN.
module prv32_exec_ctrl #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] ILLEGAL_RESULT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_shamt,
  output logic [3:0]      alu_fn,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf,
  input  logic            alu_zf,
  input  logic            alu_vf,
  input  logic            alu_sf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_br,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target,
  output logic            out_illegal
`ifdef EXEC_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_br_taken
`endif
);

  // prv32_ALU function encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [2:0]      br_f3;
  logic            accept;
  logic            br_taken;
  logic [3:0]      dec_fn;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_br;
  logic            dec_ill;

  assign out_valid = (state == RESP);
  assign in_ready  = (state == IDLE) | ((state == RESP) & out_ready);
  assign accept    = in_valid & in_ready;

  always_comb begin
    dec_fn  = ALU_ADD;
    dec_a   = in_rs1;
    dec_b   = in_rs2;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_b = (in_opcode == OPC_OP) ? in_rs2 : in_imm;
        case (in_funct3)
          3'b000:  dec_fn = ((in_opcode == OPC_OP) && in_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_fn = ALU_SLL;
          3'b010:  dec_fn = ALU_SLT;
          3'b011:  dec_fn = ALU_SLTU;
          3'b100:  dec_fn = ALU_XOR;
          3'b101:  dec_fn = in_funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_fn = ALU_OR;
          default: dec_fn = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_fn = ALU_PASS;
        dec_b  = in_imm;
      end
      OPC_AUIPC: begin
        dec_a = in_pc;
        dec_b = in_imm;
      end
      OPC_BRANCH: begin
        if (in_funct3 == 3'b010 || in_funct3 == 3'b011) begin
          dec_ill = 1'b1;
        end else begin
          dec_fn = ALU_SUB;
          dec_br = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Branch conditions come from the ALU's rs1 - rs2 flags; cf set means no borrow (rs1 >= rs2 unsigned)
  always_comb begin
    br_taken = 1'b0;
    case (br_f3)
      3'b000:  br_taken = alu_zf;
      3'b001:  br_taken = ~alu_zf;
      3'b100:  br_taken = alu_sf ^ alu_vf;
      3'b101:  br_taken = ~(alu_sf ^ alu_vf);
      3'b110:  br_taken = ~alu_cf;
      3'b111:  br_taken = alu_cf;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      br_f3         <= 3'b000;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_shamt     <= '0;
      alu_fn        <= ALU_ADD;
      out_result    <= '0;
      out_br        <= 1'b0;
      out_br_taken  <= 1'b0;
      out_br_target <= '0;
      out_illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) state <= EXEC;
        EXEC: begin
          out_result   <= out_illegal ? ILLEGAL_RESULT : (out_br ? '0 : alu_r);
          out_br_taken <= out_br & br_taken;
          state        <= RESP;
        end
        RESP: if (out_ready) state <= in_valid ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
      // out_br/out_illegal double as the pending-op flags consumed in EXEC
      if (accept) begin
        alu_a         <= dec_a;
        alu_b         <= dec_b;
        alu_shamt     <= dec_b[4:0];
        alu_fn        <= dec_fn;
        br_f3         <= in_funct3;
        out_br        <= dec_br;
        out_illegal   <= dec_ill;
        out_br_target <= in_pc + in_imm;
      end
    end
  end

`ifdef EXEC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops      <= '0;
      perf_br_taken <= '0;
    end else if (out_valid && out_ready) begin
      perf_ops <= perf_ops + 32'd1;
      if (out_br_taken) perf_br_taken <= perf_br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prv32_exec_ctrl.sv
// tb/tb_prv32_exec_ctrl.sv - randomized self-checking bench for prv32_exec_ctrl with an ALU model and reference model
// Perf counter checks are compiled in when EXEC_CTRL_PERF_EN is defined.
module tb_prv32_exec_ctrl;

  localparam logic [31:0] ILL = 32'hBAD0_0BAD;

  localparam logic [3:0] F_ADD = 4'b0000, F_SUB = 4'b0001, F_PASS = 4'b0011, F_OR = 4'b0100;
  localparam logic [3:0] F_AND = 4'b0101, F_XOR = 4'b0111, F_SRL = 4'b1000, F_SLL = 4'b1001;
  localparam logic [3:0] F_SRA = 4'b1010, F_SLT = 4'b1101, F_SLTU = 4'b1111;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1, rs2, imm, pc;
  } op_t;

  typedef struct {
    logic [31:0] result;
    logic        br, taken, ill;
    logic [31:0] target;
    int          rdy;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, in_funct7_5 = 1'b0;
  logic [6:0] in_opcode = '0;
  logic [2:0] in_funct3 = '0;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pc = '0;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [4:0] alu_shamt;
  logic [3:0] alu_fn;
  logic alu_cf, alu_zf, alu_vf, alu_sf;
  logic out_valid, out_br, out_br_taken, out_illegal;
  logic [31:0] out_result, out_br_target;
`ifdef EXEC_CTRL_PERF_EN
  logic [31:0] perf_ops, perf_br_taken;
  int exp_ops = 0, exp_taken = 0;
`endif

  int n_chk = 0, n_fail = 0, cyc = 0, mode = 1;
  exp_t q[$];

  prv32_exec_ctrl #(.XLEN(32), .ILLEGAL_RESULT(ILL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_fn(alu_fn),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_br(out_br), .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .out_illegal(out_illegal)
`ifdef EXEC_CTRL_PERF_EN
    , .perf_ops(perf_ops), .perf_br_taken(perf_br_taken)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External prv32_ALU: flags come from the add/sub path
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_bb  = (alu_fn == F_SUB) ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_a} + {1'b0, alu_bb} + {32'b0, (alu_fn == F_SUB)};
    alu_cf  = alu_sum[32];
    alu_zf  = (alu_sum[31:0] == 32'b0);
    alu_sf  = alu_sum[31];
    alu_vf  = (alu_a[31] == alu_bb[31]) && (alu_sum[31] != alu_a[31]);
    case (alu_fn)
      F_ADD, F_SUB: alu_r = alu_sum[31:0];
      F_PASS: alu_r = alu_b;
      F_OR:   alu_r = alu_a | alu_b;
      F_AND:  alu_r = alu_a & alu_b;
      F_XOR:  alu_r = alu_a ^ alu_b;
      F_SRL:  alu_r = alu_a >> alu_shamt;
      F_SLL:  alu_r = alu_a << alu_shamt;
      F_SRA:  alu_r = $signed(alu_a) >>> alu_shamt;
      F_SLT:  alu_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
      F_SLTU: alu_r = {31'b0, alu_a < alu_b};
      default: alu_r = 32'b0;
    endcase
  end

  always @(posedge clk) begin
    #1;
    if (mode == 0) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (mode == 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [31:0] b;
    int sh;
    e.result = 0; e.br = 0; e.taken = 0; e.ill = 0; e.rdy = 0;
    e.target = o.pc + o.imm;
    b = (o.opc == 7'b0110011) ? o.rs2 : o.imm;
    sh = int'(b % 32);
    if (o.opc == 7'b0110011 || o.opc == 7'b0010011) begin
      case (o.f3)
        0: e.result = (o.opc == 7'b0110011 && o.f7) ? o.rs1 - b : o.rs1 + b;
        1: e.result = o.rs1 << sh;
        2: e.result = ($signed(o.rs1) < $signed(b)) ? 1 : 0;
        3: e.result = (o.rs1 < b) ? 1 : 0;
        4: e.result = o.rs1 ^ b;
        5: e.result = o.f7 ? 32'($signed(o.rs1) >>> sh) : o.rs1 >> sh;
        6: e.result = o.rs1 | b;
        default: e.result = o.rs1 & b;
      endcase
    end else if (o.opc == 7'b0110111) e.result = o.imm;
    else if (o.opc == 7'b0010111) e.result = o.pc + o.imm;
    else if (o.opc == 7'b1100011 && o.f3 != 2 && o.f3 != 3) begin
      e.br = 1;
      case (o.f3)
        0: e.taken = (o.rs1 == o.rs2);
        1: e.taken = (o.rs1 != o.rs2);
        4: e.taken = ($signed(o.rs1) < $signed(o.rs2));
        5: e.taken = ($signed(o.rs1) >= $signed(o.rs2));
        6: e.taken = (o.rs1 < o.rs2);
        default: e.taken = (o.rs1 >= o.rs2);
      endcase
    end else begin
      e.ill = 1; e.result = ILL;
    end
    return e;
  endfunction

  // Per-cycle compare against the reference model
  always @(negedge clk) begin
    logic ev;
    op_t cur;
    if (!rst_n) begin
      q.delete();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_result", out_result, 0);
      chk("rst_flags", {29'b0, out_br, out_br_taken, out_illegal}, 0);
      chk("rst_target", out_br_target, 0);
      chk("rst_alu", {alu_a ^ alu_b, 27'b0, alu_shamt}, 0);
      chk("rst_alu_fn", 32'(alu_fn), 32'(F_ADD));
`ifdef EXEC_CTRL_PERF_EN
      exp_ops = 0; exp_taken = 0;
`endif
    end else begin
      ev = (q.size() > 0) && (cyc >= q[0].rdy);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || (ev && out_ready)));
      if (ev) begin
        chk("m_result", out_result, q[0].result);
        chk("m_br", 32'(out_br), 32'(q[0].br));
        chk("m_taken", 32'(out_br_taken), 32'(q[0].taken));
        chk("m_illegal", 32'(out_illegal), 32'(q[0].ill));
        chk("m_target", out_br_target, q[0].target);
      end
`ifdef EXEC_CTRL_PERF_EN
      chk("perf_ops", perf_ops, 32'(exp_ops));
      chk("perf_br_taken", perf_br_taken, 32'(exp_taken));
`endif
      if (ev && out_ready) begin
`ifdef EXEC_CTRL_PERF_EN
        exp_ops++;
        if (q[0].taken) exp_taken++;
`endif
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        cur = '{in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_pc};
        q.push_back(model(cur));
        q[q.size()-1].rdy = cyc + 2;
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic drive(input op_t o, output int waited);
    in_opcode = o.opc; in_funct3 = o.f3; in_funct7_5 = o.f7;
    in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm; in_pc = o.pc;
    in_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_resp(input string name, input logic [31:0] res, input logic br,
                             input logic taken, input logic [31:0] tgt, input logic ill);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk({name, "_latency"}, 32'(n), 2);
    chk({name, "_result"}, out_result, res);
    chk({name, "_br"}, 32'(out_br), 32'(br));
    chk({name, "_taken"}, 32'(out_br_taken), 32'(taken));
    chk({name, "_target"}, out_br_target, tgt);
    chk({name, "_illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] c [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 40);
      1: return c[$urandom_range(0, 4)];
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    logic [6:0] opcs [5] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1100011};
    int s = $urandom_range(0, 9);
    o.opc = (s < 3) ? opcs[0] : (s < 5) ? opcs[1] : (s == 5) ? opcs[2] :
            (s == 6) ? opcs[3] : (s < 9) ? opcs[4] : 7'($urandom);
    o.f3 = 3'($urandom); o.f7 = 1'($urandom);
    o.rs1 = rnd32(); o.rs2 = ($urandom_range(0, 2) == 0) ? o.rs1 : rnd32();
    o.imm = rnd32(); o.pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    return o;
  endfunction

  initial begin
    int w;
    op_t o;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    op_t o;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 1;
    sync();
    drive('{7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0}, w);
    expect_resp("sub", 32'hFFFF_FFFE, 0, 0, 32'h0, 0);
    sync();
    drive('{7'b1100011, 3'b110, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100}, w);
    expect_resp("bltu", 32'h0, 1, 1, 32'hF8, 0);
    sync();
    drive('{7'b1100011, 3'b100, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100}, w);
    expect_resp("blt", 32'h0, 1, 0, 32'hF8, 0);
    sync();
    drive('{7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h404, 32'd0}, w);
    expect_resp("srai", 32'hF800_0000, 0, 0, 32'h404, 0);
    sync();
    drive('{7'h7F, 3'b000, 1'b0, 32'd3, 32'd4, 32'h10, 32'h20}, w);
    expect_resp("ill_opc", ILL, 0, 0, 32'h30, 1);
    sync();
    drive('{7'b1100011, 3'b010, 1'b0, 32'd3, 32'd3, 32'h8, 32'h40}, w);
    expect_resp("ill_br", ILL, 0, 0, 32'h48, 1);

    // Hold the response for 5 cycles, then release with a new request on the same edge
    sync();
    mode = 2; out_ready = 1'b0;
    drive('{7'b0110011, 3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0}, w);
    expect_resp("hold", 32'h00F0_1200, 0, 0, 32'h0, 0);
    repeat (4) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_result", out_result, 32'h00F0_1200);
    end
    @(posedge clk); #1;
    mode = 1; out_ready = 1'b1;
    drive('{7'b0110111, 3'b000, 1'b0, 32'd9, 32'd9, 32'hABCD_E000, 32'h4}, w);
    chk("b2b_same_edge", 32'(w), 1);
    expect_resp("b2b", 32'hABCD_E000, 0, 0, 32'hABCD_E004, 0);

    // Reset while the op sits in EXEC
    sync();
    drive('{7'b0110011, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 32'd0}, w);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstx_valid", 32'(out_valid), 0);
    chk("rstx_result", out_result, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstx_no_valid", 32'(out_valid), 0);
    end

    sync();
    drive('{7'b1100011, 3'b000, 1'b0, 32'd4, 32'd4, 32'h10, 32'h0}, w);
    expect_resp("beq", 32'h0, 1, 1, 32'h10, 0);
    sync();
    drive('{7'b1100011, 3'b001, 1'b0, 32'd1, 32'd2, 32'h20, 32'h0}, w);
    expect_resp("bne", 32'h0, 1, 1, 32'h20, 0);
    sync();
    drive('{7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h30}, w);
    expect_resp("auipc", 32'h1030, 0, 0, 32'h1030, 0);
`ifdef EXEC_CTRL_PERF_EN
    @(negedge clk);
    chk("perf3_ops", perf_ops, 32'd3);
    chk("perf3_taken", perf_br_taken, 32'd2);
`endif

    mode = 0;
    for (int i = 0; i < 300; i++) begin
      sync();
      repeat ($urandom_range(0, 2)) sync();
      o = rnd_op();
      drive(o, w);
    end
    mode = 1;
    for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
